// File: rtl/snoop_state_machine_pkg.sv
// Shared line-state, CPU-action and bus-message codes for the MSI snoop controller.
// Also provides a helper that maps the unused state code onto Invalid.
package snoop_state_machine_pkg;

    typedef enum logic [1:0] {
        ST_INVALID  = 2'b00,
        ST_SHARED   = 2'b01,
        ST_MODIFIED = 2'b10
    } line_state_e;

    typedef enum logic [2:0] {
        CPU_NOP     = 3'b000,
        CPU_RD_HIT  = 3'b001,
        CPU_RD_MISS = 3'b010,
        CPU_WR_HIT  = 3'b011,
        CPU_WR_MISS = 3'b100
    } cpu_action_e;

    typedef enum logic [2:0] {
        BUS_NONE    = 3'b000,
        BUS_RD_MISS = 3'b001,
        BUS_WR_MISS = 3'b010,
        BUS_INV     = 3'b011
    } bus_msg_e;

    function automatic line_state_e norm_state(input logic [1:0] s);
        return (s == 2'b11) ? ST_INVALID : line_state_e'(s);
    endfunction

endpackage

// File: rtl/snoop_state_machine_snoop_responder.sv
// Snooper half: reacts to a remote bus message against the local copy of the line.
// Results are registered on each enabled edge and held otherwise.
module snoop_responder
    import snoop_state_machine_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              active_i,
    input  logic              cache_hit_i,
    input  logic [1:0]        state_i,
    input  logic [2:0]        bus_msg_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        proc_id_i,
    output logic              wb_o,
    output logic              abort_o,
    output logic              hit_o,
    output logic [1:0]        state_o,
    output logic [1:0]        proc_o,
    output logic [DATA_W-1:0] data_o
);

    logic              wb_d, wb_q;
    logic              abort_d, abort_q;
    logic              hit_q;
    line_state_e       st_cur, st_d;
    logic [1:0]        state_q;
    logic [1:0]        proc_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        st_cur  = norm_state(state_i);
        st_d    = st_cur;
        wb_d    = 1'b0;
        abort_d = 1'b0;
        data_d  = cache_hit_i ? data_i : '0;
        if (cache_hit_i) begin
            case (st_cur)
                ST_SHARED: begin
                    case (bus_msg_i)
                        BUS_WR_MISS,
                        BUS_INV:  st_d = ST_INVALID;
                        default:  st_d = ST_SHARED;
                    endcase
                end
                ST_MODIFIED: begin
                    case (bus_msg_i)
                        BUS_RD_MISS: begin
                            st_d    = ST_SHARED;
                            wb_d    = 1'b1;
                            abort_d = 1'b1;
                        end
                        BUS_WR_MISS: begin
                            st_d    = ST_INVALID;
                            wb_d    = 1'b1;
                            abort_d = 1'b1;
                        end
                        BUS_INV: st_d = ST_INVALID;
                        default: st_d = ST_MODIFIED;
                    endcase
                end
                default: st_d = st_cur;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q    <= 1'b0;
            abort_q <= 1'b0;
            hit_q   <= 1'b0;
            state_q <= 2'b00;
            proc_q  <= 2'b00;
            data_q  <= '0;
        end else if (active_i) begin
            wb_q    <= wb_d;
            abort_q <= abort_d;
            hit_q   <= cache_hit_i;
            state_q <= st_d;
            proc_q  <= proc_id_i;
            data_q  <= data_d;
        end
    end

    assign wb_o    = wb_q;
    assign abort_o = abort_q;
    assign hit_o   = hit_q;
    assign state_o = state_q;
    assign proc_o  = proc_q;
    assign data_o  = data_q;

endmodule

// File: rtl/snoop_state_machine.sv
// MSI snoop controller: requester transitions for local CPU accesses,
// snooper transitions delegated to snoop_responder.
module snoop_state_machine
    import snoop_state_machine_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_active,
    input  logic [2:0]        cpu_action,
    input  logic [1:0]        req_state_in,
    input  logic [1:0]        proc_id,
    output logic              req_wb,
    output logic [1:0]        req_state_out,
    output logic [2:0]        req_bus_msg,
    output logic [1:0]        req_proc,
    input  logic              snp_active,
    input  logic              snp_cache_hit,
    input  logic [1:0]        snp_state_in,
    input  logic [2:0]        snp_bus_msg,
    input  logic [DATA_W-1:0] snp_data_in,
    output logic              snp_wb,
    output logic              abort_mem_access,
    output logic              snp_hit,
    output logic [1:0]        snp_state_out,
    output logic [1:0]        snp_proc,
    output logic [DATA_W-1:0] snp_data_out
);

    line_state_e st_cur, st_d;
    bus_msg_e    msg_d;
    logic        wb_d;
    logic        wb_q;
    logic [1:0]  state_q;
    logic [2:0]  msg_q;
    logic [1:0]  proc_q;

    always_comb begin
        st_cur = norm_state(req_state_in);
        st_d   = st_cur;
        msg_d  = BUS_NONE;
        wb_d   = 1'b0;
        case (st_cur)
            ST_INVALID: begin
                case (cpu_action)
                    CPU_RD_MISS: begin
                        st_d  = ST_SHARED;
                        msg_d = BUS_RD_MISS;
                    end
                    CPU_WR_MISS: begin
                        st_d  = ST_MODIFIED;
                        msg_d = BUS_WR_MISS;
                    end
                    default: st_d = ST_INVALID;
                endcase
            end
            ST_SHARED: begin
                case (cpu_action)
                    CPU_RD_MISS: msg_d = BUS_RD_MISS;
                    CPU_WR_HIT: begin
                        st_d  = ST_MODIFIED;
                        msg_d = BUS_INV;
                    end
                    CPU_WR_MISS: begin
                        st_d  = ST_MODIFIED;
                        msg_d = BUS_WR_MISS;
                    end
                    default: st_d = ST_SHARED;
                endcase
            end
            ST_MODIFIED: begin
                // a miss evicts the dirty line, so it must be written back first
                case (cpu_action)
                    CPU_RD_MISS: begin
                        st_d  = ST_SHARED;
                        msg_d = BUS_RD_MISS;
                        wb_d  = 1'b1;
                    end
                    CPU_WR_MISS: begin
                        msg_d = BUS_WR_MISS;
                        wb_d  = 1'b1;
                    end
                    default: st_d = ST_MODIFIED;
                endcase
            end
            default: st_d = ST_INVALID;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_q    <= 1'b0;
            state_q <= 2'b00;
            msg_q   <= 3'b000;
            proc_q  <= 2'b00;
        end else if (req_active) begin
            wb_q    <= wb_d;
            state_q <= st_d;
            msg_q   <= msg_d;
            proc_q  <= proc_id;
        end
    end

    assign req_wb        = wb_q;
    assign req_state_out = state_q;
    assign req_bus_msg   = msg_q;
    assign req_proc      = proc_q;

    snoop_responder #(
        .DATA_W(DATA_W)
    ) u_snoop (
        .clk_i      (clock),
        .rst_ni     (reset),
        .active_i   (snp_active),
        .cache_hit_i(snp_cache_hit),
        .state_i    (snp_state_in),
        .bus_msg_i  (snp_bus_msg),
        .data_i     (snp_data_in),
        .proc_id_i  (proc_id),
        .wb_o       (snp_wb),
        .abort_o    (abort_mem_access),
        .hit_o      (snp_hit),
        .state_o    (snp_state_out),
        .proc_o     (snp_proc),
        .data_o     (snp_data_out)
    );

endmodule

// File: tb/tb_snoop_state_machine.sv
// Directed vector bench for snoop_state_machine: table-driven transitions
// plus hand sequences for hold and asynchronous reset behaviour.
module tb_snoop_state_machine;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_active;
    logic [2:0] cpu_action;
    logic [1:0] req_state_in;
    logic [1:0] proc_id;
    logic       req_wb;
    logic [1:0] req_state_out;
    logic [2:0] req_bus_msg;
    logic [1:0] req_proc;
    logic       snp_active;
    logic       snp_cache_hit;
    logic [1:0] snp_state_in;
    logic [2:0] snp_bus_msg;
    logic [7:0] snp_data_in;
    logic       snp_wb;
    logic       abort_mem_access;
    logic       snp_hit;
    logic [1:0] snp_state_out;
    logic [1:0] snp_proc;
    logic [7:0] snp_data_out;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    snoop_state_machine #(.DATA_W(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_active      (req_active),
        .cpu_action      (cpu_action),
        .req_state_in    (req_state_in),
        .proc_id         (proc_id),
        .req_wb          (req_wb),
        .req_state_out   (req_state_out),
        .req_bus_msg     (req_bus_msg),
        .req_proc        (req_proc),
        .snp_active      (snp_active),
        .snp_cache_hit   (snp_cache_hit),
        .snp_state_in    (snp_state_in),
        .snp_bus_msg     (snp_bus_msg),
        .snp_data_in     (snp_data_in),
        .snp_wb          (snp_wb),
        .abort_mem_access(abort_mem_access),
        .snp_hit         (snp_hit),
        .snp_state_out   (snp_state_out),
        .snp_proc        (snp_proc),
        .snp_data_out    (snp_data_out)
    );

    // {wb,state,msg,proc} {wb,abort,hit,state,proc,data}
    typedef struct {
        logic        ra;
        logic [2:0]  cpu;
        logic [1:0]  rs;
        logic [1:0]  pid;
        logic        sa;
        logic        sh;
        logic [1:0]  ss;
        logic [2:0]  sm;
        logic [7:0]  sd;
        logic [22:0] exp;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    function automatic logic [22:0] outs();
        return {req_wb, req_state_out, req_bus_msg, req_proc,
                snp_wb, abort_mem_access, snp_hit, snp_state_out,
                snp_proc, snp_data_out};
    endfunction

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        req_active    = 1'b0;
        cpu_action    = 3'b000;
        req_state_in  = 2'b00;
        proc_id       = 2'b00;
        snp_active    = 1'b0;
        snp_cache_hit = 1'b0;
        snp_state_in  = 2'b00;
        snp_bus_msg   = 3'b000;
        snp_data_in   = 8'h00;
    endtask

    initial begin
        // requester transitions
        vec[0]  = '{1'b1, 3'b010, 2'b00, 2'd1, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b01, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[1]  = '{1'b1, 3'b100, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b10, 3'b010, 2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[2]  = '{1'b1, 3'b001, 2'b00, 2'd0, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[3]  = '{1'b1, 3'b001, 2'b01, 2'd3, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b01, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[4]  = '{1'b1, 3'b010, 2'b01, 2'd1, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b01, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[5]  = '{1'b1, 3'b011, 2'b01, 2'd2, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b10, 3'b011, 2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[6]  = '{1'b1, 3'b100, 2'b01, 2'd0, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b10, 3'b010, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[7]  = '{1'b1, 3'b001, 2'b10, 2'd1, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b10, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[8]  = '{1'b1, 3'b011, 2'b10, 2'd1, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b10, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[9]  = '{1'b1, 3'b010, 2'b10, 2'd2, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b1, 2'b01, 3'b001, 2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[10] = '{1'b1, 3'b100, 2'b10, 2'd3, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b1, 2'b10, 3'b010, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        vec[11] = '{1'b1, 3'b111, 2'b01, 2'd0, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00}};
        // snooper transitions, requester inactive so it holds
        vec[12] = '{1'b0, 3'b010, 2'b00, 2'd3, 1'b1, 1'b1, 2'b10, 3'b001, 8'h4D,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b1, 1'b1, 1'b1, 2'b01, 2'd3, 8'h4D}};
        vec[13] = '{1'b0, 3'b000, 2'b00, 2'd3, 1'b1, 1'b1, 2'b01, 3'b011, 8'hAA,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'd3, 8'hAA}};
        vec[14] = '{1'b0, 3'b000, 2'b00, 2'd3, 1'b1, 1'b1, 2'b01, 3'b001, 8'h11,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b01, 2'd3, 8'h11}};
        vec[15] = '{1'b0, 3'b000, 2'b00, 2'd3, 1'b1, 1'b1, 2'b10, 3'b010, 8'h22,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'd3, 8'h22}};
        vec[16] = '{1'b0, 3'b000, 2'b00, 2'd3, 1'b1, 1'b1, 2'b10, 3'b011, 8'h33,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'd3, 8'h33}};
        vec[17] = '{1'b0, 3'b000, 2'b00, 2'd3, 1'b1, 1'b1, 2'b10, 3'b000, 8'h44,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 2'b10, 2'd3, 8'h44}};
        vec[18] = '{1'b0, 3'b000, 2'b00, 2'd3, 1'b1, 1'b0, 2'b01, 3'b010, 8'h55,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd3, 8'h00}};
        vec[19] = '{1'b0, 3'b000, 2'b10, 2'd1, 1'b0, 1'b1, 2'b10, 3'b001, 8'h77,
                    {1'b0, 2'b01, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd3, 8'h00}};
        // both halves in the same cycle
        vec[20] = '{1'b1, 3'b010, 2'b10, 2'd2, 1'b1, 1'b1, 2'b01, 3'b010, 8'h66,
                    {1'b1, 2'b01, 3'b001, 2'd2, 1'b0, 1'b0, 1'b1, 2'b00, 2'd2, 8'h66}};

        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("reset_state", 23'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            req_active    = vec[i].ra;
            cpu_action    = vec[i].cpu;
            req_state_in  = vec[i].rs;
            proc_id       = vec[i].pid;
            snp_active    = vec[i].sa;
            snp_cache_hit = vec[i].sh;
            snp_state_in  = vec[i].ss;
            snp_bus_msg   = vec[i].sm;
            snp_data_in   = vec[i].sd;
            @(posedge clock);
            #1 check($sformatf("vec%0d", i), vec[i].exp);
        end

        // asynchronous reset between edges discards the pending result
        @(negedge clock);
        req_active    = 1'b1;
        cpu_action    = 3'b011;
        req_state_in  = 2'b01;
        proc_id       = 2'd1;
        snp_active    = 1'b1;
        snp_cache_hit = 1'b1;
        snp_state_in  = 2'b10;
        snp_bus_msg   = 3'b001;
        snp_data_in   = 8'h9C;
        #2 reset = 1'b0;
        #1 check("rst_async", 23'd0);
        @(posedge clock);
        #1 check("rst_hold", 23'd0);
        @(negedge clock);
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1 check("post_release_idle", 23'd0);

        @(negedge clock);
        req_active    = 1'b1;
        cpu_action    = 3'b011;
        req_state_in  = 2'b01;
        proc_id       = 2'd2;
        snp_active    = 1'b1;
        snp_cache_hit = 1'b1;
        snp_state_in  = 2'b10;
        snp_bus_msg   = 3'b001;
        snp_data_in   = 8'h4D;
        @(posedge clock);
        #1 check("first_edge",
                 {1'b0, 2'b10, 3'b011, 2'd2, 1'b1, 1'b1, 1'b1, 2'b01, 2'd2, 8'h4D});

        @(negedge clock);
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snoop_state_machine.md
SNOOP_STATE_MACHINE -- requirements
Module: snoop_state_machine

Interface
REQ-001 Parameter DATA_W, default 8: width of the cache-line data word.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_active  input  1  requester-machine enable (local CPU access pending).
REQ-005 cpu_action  input  3  001 read hit, 010 read miss, 011 write hit, 100 write miss; others no-op.
REQ-006 req_state_in  input  2  current line state at requester: 00 Invalid, 01 Shared, 10 Modified; 11 treated as Invalid.
REQ-007 proc_id  input  2  index of this processor.
REQ-008 req_wb  output  1  requester must write back its line.
REQ-009 req_state_out  output  2  next line state at requester.
REQ-010 req_bus_msg  output  3  bus message issued: 000 none, 001 read miss, 010 write miss, 011 invalidate.
REQ-011 req_proc  output  2  proc_id latched with the requester result.
REQ-012 snp_active  input  1  snooper-machine enable (remote message to process).
REQ-013 snp_cache_hit  input  1  local cache holds the snooped line valid.
REQ-014 snp_state_in  input  2  current line state at snooper.
REQ-015 snp_bus_msg  input  3  bus message from remote requester, same encoding as REQ-010.
REQ-016 snp_data_in  input  DATA_W  local line data.
REQ-017 snp_wb  output  1  snooper must write back.
REQ-018 abort_mem_access  output  1  memory read cancelled; snooper supplies data.
REQ-019 snp_hit  output  1  registered copy of snp_cache_hit.
REQ-020 snp_state_out  output  2  next line state at snooper.
REQ-021 snp_proc  output  2  proc_id latched with the snooper result.
REQ-022 snp_data_out  output  DATA_W  data supplied to requester; 0 when no hit.

Function
REQ-023 Both halves register outputs on the rising edge where their active input is 1; results valid one cycle later; outputs hold while active is 0.
REQ-024 Halves are independent; both active in one cycle each update.
REQ-025 Requester, Invalid: read miss -> Shared, msg 001, wb 0; write miss -> Modified, msg 010, wb 0; hits (illegal) -> Invalid, msg 000.
REQ-026 Requester, Shared: read hit -> Shared, 000; read miss -> Shared, 001; write hit -> Modified, 011; write miss -> Modified, 010; wb 0 throughout.
REQ-027 Requester, Modified: read/write hit -> Modified, 000, wb 0; read miss -> Shared, 001, wb 1; write miss -> Modified, 010, wb 1.
REQ-028 Requester undefined cpu_action: state unchanged, msg 000, wb 0.
REQ-029 Snooper with snp_cache_hit 0: state unchanged, wb 0, abort 0, hit 0, data 0.
REQ-030 Snooper hit, Shared: msg 001 -> Shared; 010 or 011 -> Invalid; wb 0, abort 0.
REQ-031 Snooper hit, Modified: msg 001 -> Shared, wb 1, abort 1; msg 010 -> Invalid, wb 1, abort 1; msg 011 -> Invalid, wb 0, abort 0.
REQ-032 Snooper hit, msg 000: state unchanged, wb 0, abort 0.
REQ-033 snp_data_out = snp_data_in whenever registered snp_hit is 1.

Reset
REQ-034 reset low clears every output to 0 immediately, independent of clock; reset mid-operation discards the pending result.
REQ-035 First active edge after reset release is processed normally.

Structure
REQ-036 Shared package holds state codes (INVALID, SHARED, MODIFIED), cpu_action codes and bus-message codes.
REQ-037 Snooper half is the sub-module snoop_responder; requester logic stays in the top.

Verification
REQ-038 Shared, write hit, req_active 1 -> next cycle req_state_out 10, req_bus_msg 011, req_wb 0.
REQ-039 Modified, read miss -> req_state_out 01, req_bus_msg 001, req_wb 1.
REQ-040 Snooper Modified, hit 1, msg 001, data 0x4D -> snp_state_out 01, snp_wb 1, abort 1, snp_data_out 0x4D.
REQ-041 Snooper Shared, hit 1, msg 011 -> snp_state_out 00, snp_wb 0, abort 0.
REQ-042 Both halves active together, then reset low between edges -> all outputs 0 at once, held until next active edge.
